ifc: RTL and testbench

//  Registered range-limited priority encoder over a small array of byte lanes.

---
 rtl/ifc_pkg.sv | 77 +++++++
 rtl/ifc_lane_prio_enc.sv | 19 +
 rtl/ifc.sv | 72 +++++++
 tb/tb_ifc.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ifc_pkg.sv
// ----------------------------------------------------------------------------
// ifc_pkg
//  Shared definitions for the range-limited lane priority encoder.
//  Holds the default lane geometry, the request/result structs and the
//  combinational encoder_function that the lane_prio_enc block wraps.
//
//  Contents:
//    PKG_NUM_LANES    default number of byte lanes
//    PKG_LANE_W       default bits per lane
//    PKG_IDX_W        default lane index width (2**IDX_W >= NUM_LANES)
//    encoder_func_in  {vec_in, left, right}  one encode request
//    encoder_func_out {found, vec_index}     one encode result
//    window_mask()    eligible-lane mask for an inclusive [left..right] window
//    encoder_function() lowest eligible non-zero lane
// ----------------------------------------------------------------------------
package ifc_pkg;

    localparam int PKG_NUM_LANES = 4;
    localparam int PKG_LANE_W    = 8;
    localparam int PKG_IDX_W     = 3;

    typedef logic [PKG_LANE_W-1:0] lane_t;
    typedef logic [PKG_IDX_W-1:0]  idx_t;

    // Highest physical lane number; window ends beyond it are clamped here.
    localparam idx_t LAST_LANE = idx_t'(PKG_NUM_LANES - 1);

    typedef struct packed {
        lane_t [PKG_NUM_LANES-1:0] vec_in;
        idx_t                      left;
        idx_t                      right;
    } encoder_func_in;

    typedef struct packed {
        logic found;
        idx_t vec_index;
    } encoder_func_out;

    // A lane is eligible when it lies inside [left..min(right, LAST_LANE)].
    // An empty window (left > right, or left past the last lane) simply
    // yields an all-zero mask, so no separate special case is needed.
    function automatic logic [PKG_NUM_LANES-1:0] window_mask(
        input idx_t left,
        input idx_t right
    );
        logic [PKG_NUM_LANES-1:0] mask;
        idx_t                     hi;
        idx_t                     lane;
        hi   = (right > LAST_LANE) ? LAST_LANE : right;
        mask = '0;
        for (int i = 0; i < PKG_NUM_LANES; i++) begin
            lane    = idx_t'(i);
            mask[i] = (lane >= left) && (lane <= hi);
        end
        return mask;
    endfunction

    // Scan eligible lanes from low to high; the first non-zero lane wins.
    // Lane contents never affect priority, only whether the lane is zero.
    // With nothing found the index is forced to zero.
    function automatic encoder_func_out encoder_function(
        input encoder_func_in f_in
    );
        encoder_func_out          f_out;
        logic [PKG_NUM_LANES-1:0] mask;
        mask  = window_mask(f_in.left, f_in.right);
        f_out = '0;
        for (int i = 0; i < PKG_NUM_LANES; i++) begin
            if (!f_out.found && mask[i] && (f_in.vec_in[i] != '0)) begin
                f_out.found     = 1'b1;
                f_out.vec_index = idx_t'(i);
            end
        end
        return f_out;
    endfunction

endpackage : ifc_pkg

// File: rtl/ifc_lane_prio_enc.sv
// ----------------------------------------------------------------------------
// lane_prio_enc
//  Purely combinational window-limited priority pick. Takes one packed
//  encode request and produces the result via encoder_function.
//
//  Ports:
//    enc_in   in   encoder_func_in   lanes plus inclusive window bounds
//    enc_out  out  encoder_func_out  found flag and lowest eligible lane
// ----------------------------------------------------------------------------
module lane_prio_enc
    import ifc_pkg::*;
(
    input  encoder_func_in  enc_in,
    output encoder_func_out enc_out
);

    assign enc_out = encoder_function(enc_in);

endmodule : lane_prio_enc

// File: rtl/ifc.sv
// ----------------------------------------------------------------------------
// ifc
//  Registered range-limited priority encoder over a small array of byte
//  lanes. Each in_valid request is encoded combinationally and the result
//  is registered, giving a one-cycle latency with one result per cycle.
//  Between requests found/vec_index hold their last values.
//
//  Ports:
//    clk        in   1                    rising-edge clock
//    rst_n      in   1                    async active-low reset
//    in_valid   in   1                    request strobe
//    input_vec  in   NUM_LANES x LANE_W   lane array
//    left       in   IDX_W                window start lane (inclusive)
//    right      in   IDX_W                window end lane (inclusive)
//    out_valid  out  1                    result valid, one cycle per request
//    found      out  1                    non-zero lane found in window
//    vec_index  out  IDX_W                lowest non-zero lane in window
// ----------------------------------------------------------------------------
module ifc
    import ifc_pkg::*;
#(
    parameter int NUM_LANES = PKG_NUM_LANES,
    parameter int LANE_W    = PKG_LANE_W,
    parameter int IDX_W     = PKG_IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [LANE_W-1:0] input_vec [NUM_LANES-1:0],
    input  logic [IDX_W-1:0]  left,
    input  logic [IDX_W-1:0]  right,
    output logic              out_valid,
    output logic              found,
    output logic [IDX_W-1:0]  vec_index
);

    encoder_func_in  enc_in;
    encoder_func_out enc_out;

    // Gather the unpacked lane array and window bounds into one request.
    always_comb begin
        enc_in       = '0;
        enc_in.left  = left;
        enc_in.right = right;
        for (int i = 0; i < NUM_LANES; i++) begin
            enc_in.vec_in[i] = input_vec[i];
        end
    end

    lane_prio_enc u_lane_prio_enc (
        .enc_in  (enc_in),
        .enc_out (enc_out)
    );

    // Result register. out_valid mirrors the request strobe one cycle late;
    // the result fields only load on a request so they hold otherwise.
    // An asynchronous reset drops any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            found     <= 1'b0;
            vec_index <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                found     <= enc_out.found;
                vec_index <= enc_out.vec_index;
            end
        end
    end

endmodule : ifc

// File: tb/tb_ifc.sv
// ----------------------------------------------------------------------------
// tb_ifc
//  Self-checking bench for ifc: directed requests with literal expected
//  results, an exhaustive window sweep over a few lane patterns, and a
//  behavioural model compared against the outputs on every falling edge.
// ----------------------------------------------------------------------------
module tb_ifc;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] input_vec [3:0];
    logic [2:0] left;
    logic [2:0] right;
    logic       out_valid;
    logic       found;
    logic [2:0] vec_index;

    int checks;
    int errors;
    bit started;

    logic       m_valid;
    logic       m_found;
    logic [2:0] m_index;

    ifc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .input_vec (input_vec),
        .left      (left),
        .right     (right),
        .out_valid (out_valid),
        .found     (found),
        .vec_index (vec_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour: clamp the window end, walk the window upward and
    // stop on the first non-zero lane.
    function automatic void model(input logic [7:0] v [3:0], input int l,
                                  input int r, output logic f,
                                  output logic [2:0] idx);
        int hi;
        f   = 1'b0;
        idx = 3'd0;
        hi  = (r > 3) ? 3 : r;
        for (int i = l; i <= hi; i++) begin
            if (v[i] != 8'h00) begin
                f   = 1'b1;
                idx = 3'(i);
                return;
            end
        end
    endfunction

    task automatic compare(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state advances on the same edges as the design.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_found = 1'b0;
            m_index = 3'd0;
        end else begin
            m_valid = in_valid;
            if (in_valid) model(input_vec, int'(left), int'(right), m_found, m_index);
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (started) begin
            compare("model out_valid", int'(out_valid), int'(m_valid));
            compare("model found", int'(found), int'(m_found));
            compare("model vec_index", int'(vec_index), int'(m_index));
        end
    end

    task automatic applyStimulus(input logic [7:0] l0, input logic [7:0] l1,
                                 input logic [7:0] l2, input logic [7:0] l3,
                                 input logic [2:0] lo, input logic [2:0] hi);
        @(negedge clk);
        input_vec[0] = l0;
        input_vec[1] = l1;
        input_vec[2] = l2;
        input_vec[3] = l3;
        left         = lo;
        right        = hi;
        in_valid     = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic exp_found,
                               input logic [2:0] exp_index);
        @(negedge clk);
        compare({name, " out_valid"}, int'(out_valid), 1);
        compare({name, " found"}, int'(found), int'(exp_found));
        compare({name, " vec_index"}, int'(vec_index), int'(exp_index));
        in_valid = 1'b0;
    endtask

    logic [31:0] pats [4];
    logic [31:0] pat;
    logic [7:0]  mv [3:0];
    logic        mf;
    logic [2:0]  mi;

    initial begin
        checks    = 0;
        errors    = 0;
        started   = 1'b0;
        in_valid  = 1'b0;
        left      = 3'd0;
        right     = 3'd0;
        for (int i = 0; i < 4; i++) input_vec[i] = 8'h00;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        compare("reset out_valid", int'(out_valid), 0);
        compare("reset found", int'(found), 0);
        compare("reset vec_index", int'(vec_index), 0);

        // Pin the model itself with hand-worked cases.
        mv[0] = 8'h00; mv[1] = 8'h01; mv[2] = 8'h00; mv[3] = 8'h03;
        model(mv, 2, 3, mf, mi);
        compare("model pin found", int'(mf), 1);
        compare("model pin index", int'(mi), 3);
        mv[0] = 8'hFF; mv[1] = 8'h00; mv[2] = 8'h00; mv[3] = 8'h00;
        model(mv, 3, 1, mf, mi);
        compare("model pin empty", int'(mf), 0);

        @(negedge clk);
        rst_n   = 1'b1;
        started = 1'b1;
        $display("[TB] reset released, starting directed tests");

        applyStimulus(8'h00, 8'h01, 8'h00, 8'h03, 3'd1, 3'd3);
        checkOutput("t1", 1'b1, 3'd1);
        applyStimulus(8'h00, 8'h01, 8'h00, 8'h03, 3'd2, 3'd3);
        checkOutput("t2", 1'b1, 3'd3);
        applyStimulus(8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd3);
        checkOutput("t3", 1'b0, 3'd0);
        applyStimulus(8'hFF, 8'h00, 8'h00, 8'h00, 3'd3, 3'd1);
        checkOutput("t4", 1'b0, 3'd0);
        applyStimulus(8'h00, 8'h00, 8'h80, 8'h00, 3'd0, 3'd7);
        checkOutput("t5", 1'b1, 3'd2);
        applyStimulus(8'h10, 8'h20, 8'h30, 8'h40, 3'd2, 3'd2);
        checkOutput("single lane", 1'b1, 3'd2);
        applyStimulus(8'h10, 8'h20, 8'h30, 8'h40, 3'd4, 3'd7);
        checkOutput("left past end", 1'b0, 3'd0);

        // Outputs must hold across idle cycles.
        applyStimulus(8'h00, 8'h00, 8'h01, 8'h00, 3'd0, 3'd3);
        checkOutput("hold load", 1'b1, 3'd2);
        repeat (3) @(negedge clk);
        compare("hold out_valid", int'(out_valid), 0);
        compare("hold found", int'(found), 1);
        compare("hold vec_index", int'(vec_index), 2);

        // Reset pulse in the middle of a request drops it.
        applyStimulus(8'h00, 8'h01, 8'h00, 8'h03, 3'd1, 3'd3);
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        compare("mid reset out_valid", int'(out_valid), 0);
        compare("mid reset found", int'(found), 0);
        compare("mid reset vec_index", int'(vec_index), 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        compare("dropped request", int'(out_valid), 0);
        applyStimulus(8'h00, 8'h01, 8'h00, 8'h03, 3'd2, 3'd3);
        checkOutput("after reset", 1'b1, 3'd3);

        // Back-to-back sweep of every window over several lane patterns.
        pats[0] = 32'h03000100;
        pats[1] = 32'h00000000;
        pats[2] = 32'h800000FF;
        pats[3] = 32'h01010101;
        for (int p = 0; p < 4; p++) begin
            pat = pats[p];
            for (int l = 0; l < 8; l++) begin
                for (int r = 0; r < 8; r++) begin
                    applyStimulus(pat[7:0], pat[15:8], pat[23:16], pat[31:24],
                                  3'(l), 3'(r));
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ifc
